// File: rtl/tx_fifo_sync_param_if.sv
`default_nettype none
// ============================================================================
// tx_fifo_sync_param_if : write/read handshake bundle of the parametrised TX FIFO
// Rev 1.0
// ============================================================================
interface tx_fifo_sync_param_if #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 12
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             in_enable;
   logic             flush;
   logic             en_wr;
   logic [WIDTH-1:0] data_wr;
   logic             idle_wr;
   logic             en_rd;
   logic [WIDTH-1:0] data_rd;
   logic             idle_rd;
   logic [CW-1:0]    level;
   logic             ovf_err;
   logic             clr_err;

   modport master (
      output in_enable, flush, en_wr, data_wr, idle_rd, clr_err,
      input  idle_wr, en_rd, data_rd, level, ovf_err
   );

   modport slave (
      input  in_enable, flush, en_wr, data_wr, idle_rd, clr_err,
      output idle_wr, en_rd, data_rd, level, ovf_err
   );
endinterface
`default_nettype wire

// File: rtl/tx_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// tx_fifo_sync_param : single-clock TX FIFO, any WIDTH/DEPTH, occupancy-counted.
// Optional registered read port selected by macro TX_FIFO_OUTREG_EN.
// Rev 1.0
// ============================================================================
module tx_fifo_sync_param #(
   parameter int WIDTH        = 12,
   parameter int DEPTH        = 12,
   parameter int AFULL_MARGIN = 4
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   tx_fifo_sync_param_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] LVL_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] LVL_AFULL = CW'(DEPTH - AFULL_MARGIN);
   localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    level_q, level_d;
   logic             idle_wr_q, idle_wr_d;
   logic             ovf_err_q, ovf_err_d;
   logic             full, empty, pop_rd, push_ok, ovf_set;

   always_comb begin
      full      = (level_q == LVL_FULL);
      empty     = (level_q == '0);
      pop_rd    = bus.in_enable & bus.idle_rd & ~empty & ~bus.flush;
      push_ok   = bus.in_enable & bus.en_wr & ~full & ~bus.flush;
      ovf_set   = bus.in_enable & bus.en_wr & full & ~bus.flush;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      idle_wr_d = idle_wr_q;
      if (bus.in_enable) begin
         if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
         end else begin
            // pointers wrap modulo DEPTH so non-power-of-2 depths stay dense
            if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            if (pop_rd)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            case ({push_ok, pop_rd})
               2'b10:   level_d = level_q + CW'(1);
               2'b01:   level_d = level_q - CW'(1);
               default: level_d = level_q;
            endcase
         end
         idle_wr_d = (level_d <= LVL_AFULL);
      end
      // a same-cycle overflow wins over the clear
      ovf_err_d = ovf_set ? 1'b1 : (bus.clr_err ? 1'b0 : ovf_err_q);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         idle_wr_q <= 1'b0;
         ovf_err_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         idle_wr_q <= idle_wr_d;
         ovf_err_q <= ovf_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && push_ok) mem[wr_ptr_q] <= bus.data_wr;
   end

   assign bus.level   = level_q;
   assign bus.idle_wr = idle_wr_q;
   assign bus.ovf_err = ovf_err_q;

`ifdef TX_FIFO_OUTREG_EN
   logic             en_rd_q, en_rd_d;
   logic [WIDTH-1:0] data_rd_q, data_rd_d;

   always_comb begin
      en_rd_d   = pop_rd;
      data_rd_d = pop_rd ? mem[rd_ptr_q] : data_rd_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         en_rd_q   <= 1'b0;
         data_rd_q <= '0;
      end else begin
         en_rd_q   <= en_rd_d;
         data_rd_q <= data_rd_d;
      end
   end

   assign bus.en_rd   = en_rd_q;
   assign bus.data_rd = data_rd_q;
`else
   assign bus.en_rd   = pop_rd;
   assign bus.data_rd = mem[rd_ptr_q];
`endif
endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// tb_tx_fifo_sync_param : scoreboard bench for tx_fifo_sync_param
// Rev 1.0
// ============================================================================
module tb_tx_fifo_sync_param;
   localparam int WIDTH = 12;
   localparam int DEPTH = 12;
   localparam int AFULL = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   tx_fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   tx_fifo_sync_param #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_MARGIN(AFULL)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int rd_count = 0;
   int r0;
   logic [WIDTH-1:0] sb_q[$];
   logic [WIDTH-1:0] exp_w;
   int   m_level;
   logic m_idle, m_ovf;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every consumed word must match the oldest accepted write
   always @(negedge clk) begin
      if (reset_n && bus.en_rd) begin
         rd_count++;
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected: got en_rd=1 data 0x%0h expected no read", bus.data_rd);
         end else begin
            exp_w = sb_q.pop_front();
            check("rd_data", int'(bus.data_rd), int'(exp_w));
         end
      end
   end

   task automatic cyc(input logic en, input logic fl, input logic wr,
                      input logic [WIDTH-1:0] d, input logic rd, input logic clr);
      logic push, pop, set;
      bus.in_enable = en;
      bus.flush     = fl;
      bus.en_wr     = wr;
      bus.data_wr   = d;
      bus.idle_rd   = rd;
      bus.clr_err   = clr;
      push = en && wr && !fl && (m_level < DEPTH);
      pop  = en && rd && !fl && (m_level > 0);
      set  = en && wr && !fl && (m_level == DEPTH);
      @(posedge clk);
      #1;
      if (en && fl) begin
         m_level = 0;
         sb_q.delete();
      end else begin
         if (push) begin
            sb_q.push_back(d);
            m_level++;
         end
         if (pop) m_level--;
      end
      if (en) m_idle = (m_level <= DEPTH - AFULL);
      if (set) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      check("level", int'(bus.level), m_level);
      check("idle_wr", int'(bus.idle_wr), int'(m_idle));
      check("ovf_err", int'(bus.ovf_err), int'(m_ovf));
   endtask

   task automatic do_reset(input int n);
      reset_n       = 1'b0;
      bus.in_enable = 1'b0;
      bus.flush     = 1'b0;
      bus.en_wr     = 1'b0;
      bus.data_wr   = '0;
      bus.idle_rd   = 1'b0;
      bus.clr_err   = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset_n = 1'b1;
      m_level = 0;
      m_idle  = 1'b0;
      m_ovf   = 1'b0;
      sb_q.delete();
      check("rst_level", int'(bus.level), 0);
      check("rst_idle_wr", int'(bus.idle_wr), 0);
      check("rst_ovf_err", int'(bus.ovf_err), 0);
   endtask

   initial begin
      do_reset(2);

      // T1: first enabled cycle raises idle_wr
      cyc(1, 0, 0, '0, 0, 0);
      check("t1_idle_wr", int'(bus.idle_wr), 1);
      check("t1_rd_count", rd_count, 0);

      // T2: fill to DEPTH, then overflow
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(1, 0, 1, WIDTH'(i), 0, 0);
         if (i == 8) check("t2_idle_at8", int'(bus.idle_wr), 1);
         if (i == 9) check("t2_idle_at9", int'(bus.idle_wr), 0);
      end
      check("t2_level_full", int'(bus.level), 12);
      cyc(1, 0, 1, 12'hFFF, 0, 0);
      check("t2_ovf", int'(bus.ovf_err), 1);
      check("t2_level_hold", int'(bus.level), 12);

      // T3: drain
      repeat (DEPTH) cyc(1, 0, 0, '0, 1, 0);
      repeat (2) cyc(1, 0, 0, '0, 0, 0);
      check("t3_rd_count", rd_count, 12);
      check("t3_level", int'(bus.level), 0);
      check("t3_sb_empty", sb_q.size(), 0);

      // T4: streaming across the pointer wrap
      r0 = rd_count;
      for (int i = 0; i < 40; i++) begin
         cyc(1, 0, 1, WIDTH'(12'h100 + i), 1, 0);
         check("t4_level", int'(bus.level), 1);
      end
      repeat (3) cyc(1, 0, 0, '0, 1, 0);
      check("t4_rd_count", rd_count - r0, 40);

      // T5: flush discards contents and same-cycle write
      for (int i = 0; i < 5; i++) cyc(1, 0, 1, WIDTH'(12'h200 + i), 0, 0);
      check("t5_level5", int'(bus.level), 5);
      cyc(1, 1, 1, 12'h2FF, 0, 0);
      check("t5_flush_level", int'(bus.level), 0);
      check("t5_flush_idle", int'(bus.idle_wr), 1);
      check("t5_flush_ovf", int'(bus.ovf_err), 1);
      cyc(1, 0, 1, 12'h2AA, 0, 0);
      repeat (3) cyc(1, 0, 0, '0, 1, 0);
      check("t5_sb_empty", sb_q.size(), 0);

      // T6: freeze with traffic, then clear error while disabled
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, WIDTH'(12'h300 + i), 0, 0);
      r0 = rd_count;
      for (int i = 0; i < 10; i++) cyc(0, logic'(i % 2), 1, 12'h3F0, 1, 0);
      check("t6_level_frozen", int'(bus.level), 3);
      check("t6_no_reads", rd_count - r0, 0);
      cyc(0, 0, 0, '0, 0, 1);
      check("t6_clr", int'(bus.ovf_err), 0);
      repeat (4) cyc(1, 0, 0, '0, 1, 0);
      check("t6_sb_empty", sb_q.size(), 0);

      // T7: write while full with same-cycle pop and clear
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, WIDTH'(12'h400 + i), 0, 0);
      cyc(1, 0, 1, 12'hEEE, 1, 1);
      check("t7_ovf_wins", int'(bus.ovf_err), 1);
      check("t7_level", int'(bus.level), 11);
      repeat (13) cyc(1, 0, 0, '0, 1, 0);
      check("t7_sb_empty", sb_q.size(), 0);

      // T8: reset mid-operation loses data
      for (int i = 0; i < 4; i++) cyc(1, 0, 1, WIDTH'(12'h500 + i), 0, 0);
      do_reset(1);
      cyc(1, 0, 0, '0, 0, 0);
      check("t8_idle_wr", int'(bus.idle_wr), 1);
      cyc(1, 0, 1, 12'h555, 0, 0);
      repeat (3) cyc(1, 0, 0, '0, 1, 0);
      check("t8_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
